reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order commit unit. It is the writer side of the architectural register file and its rename-tag table.
- Allocates an entry per decoded instruction and records the destination register.
- Captures results from the common data bus (CDB) and retires entries in program order.
- Drives the register file's value-write port (set_reg/set_val) and tag-write port (set_reg_q/set_val_q/set_rdy_q).

Parameters:
ROB_WIDTH, 4, log2 of entry count; DEPTH = 2**ROB_WIDTH (default 16)

Ports:
clk_in  input  1  system clock; all state on rising edge
rst_n_in  input  1  synchronous reset, active low
rdy_in  input  1  global ready; low freezes all state and holds all outputs
issue_valid  input  1  decoder requests allocation this cycle
issue_rd  input  5  destination register of issuing instruction
issue_ready  output  1  combinational; allocation accepted iff issue_valid && issue_ready
issue_tag  output  ROB_WIDTH  combinational; tag (tail index) given to the issuing instruction
wb_valid  input  1  CDB result valid
wb_tag  input  ROB_WIDTH  CDB result tag
wb_val  input  32  CDB result value
set_reg  output  5  register to write (0 = no write); registered
set_val  output  32  value to write; registered
set_reg_q  output  5  rename entry to write (0 = no write); registered
set_val_q  output  32  tag value, zero-extended; registered
set_rdy_q  output  1  ready bit for the rename entry; registered
count  output  ROB_WIDTH+1  occupied entries

Behaviour:
- Reset (rst_n_in low at an edge): head=tail=count=0; all entries invalid; latest-tag table busy bits cleared. set_reg, set_val, set_reg_q, set_val_q and set_rdy_q are all 0.
- rdy_in low: no state change; every registered output holds its value, so the register file consumes it at the next rdy-high edge.
- Entry fields: valid, done, rd[4:0], val[31:0].
- Internal table latest[32]: a tag plus a busy bit per register.
- commit_now (combinational) = count!=0 && entry[head].done.
- need_q = commit_now && rd!=0 && latest[rd].busy && latest[rd].tag==head.
- issue_ready = count!=DEPTH && !need_q. Full blocks issue even if a commit occurs in the same cycle.
- issue_tag = tail.
- Issue (accepted, rdy_in high):
  - entry[tail] <= {valid=1, done=0, rd}; tail wraps modulo DEPTH; count+1.
  - If rd!=0: latest[rd] <= {busy=1, tail}; next cycle set_reg_q=rd, set_val_q=tail, set_rdy_q=0.
  - rd=0 allocates the entry but produces no rename write.
- Writeback: if wb_valid && entry[wb_tag].valid && !done, then val<=wb_val and done<=1. A writeback to an invalid or already-done entry is ignored.
- Commit (commit_now, rdy_in high):
  - Next cycle set_reg=rd and set_val=val; rd=0 yields set_reg=0.
  - entry[head].valid<=0; head wraps; count-1.
  - If need_q: latest[rd].busy<=0; next cycle set_reg_q=rd, set_val_q=head, set_rdy_q=1.
  - need_q suppresses issue that cycle, so the q port never has two requesters.
- Ports idle: on any rdy-high edge with no commit, set_reg and set_val become 0. With neither issue nor need_q, set_reg_q, set_val_q and set_rdy_q become 0. Writes are one-cycle pulses.
- Simultaneous issue and commit (non-need_q): both occur; count unchanged.
- Issue to the same rd as committing head: allowed only if not need_q. The newer tag wins in latest[].
- Writeback to the head in cycle N: done is set at edge N; commit at edge N+1; set_reg visible after N+1; register file updated at N+2.
- Minimum latency: issue edge E0, writeback E1, commit E2.
- Wrap-around: head and tail are ROB_WIDTH bits and wrap naturally. Full/empty are determined only by count.
- Reset mid-operation discards all in-flight entries with no commit pulse emitted.

Test Plan:
- Reset with rst_n_in=0 for 2 cycles → count=0, issue_tag=0, issue_ready=1, all set_* outputs 0.
- Issue rd=5 → tag 0 assigned; next cycle set_reg_q=5, set_val_q=0, set_rdy_q=0. Then wb tag0 val=0xDEADBEEF → 2 edges later set_reg=5, set_val=0xDEADBEEF, set_reg_q=5, set_val_q=0, set_rdy_q=1; count returns to 0.
- Out-of-order writeback: issue rd=1,2,3 (tags 0,1,2); wb tags 2,1,0 with values 30,20,10 → commits appear in order 1/10, 2/20, 3/30 on consecutive cycles.
- Fill 16 entries without writeback → issue_ready=0, count=16, a 17th issue is not accepted. Then wb tag0 → one commit; tail wraps to 0 and the next issue gets tag 0.
- Rename superseded: issue rd=7 (tag0), issue rd=7 (tag1), wb tag0 → commit writes set_reg=7, set_reg_q stays 0 (not latest), and issue_ready stays high.
- rdy_in held low for 3 cycles while a commit output is pending → set_reg/set_val held stable. First rdy-high edge advances state exactly once; rd=0 commit yields set_reg=0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue, CDB writeback and register-file write bundle for the reorder buffer
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 issue_ready;
  logic [ROB_WIDTH-1:0] issue_tag;

  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_tag;
  logic [31:0]          wb_val;

  logic [4:0]           set_reg;
  logic [31:0]          set_val;
  logic [4:0]           set_reg_q;
  logic [31:0]          set_val_q;
  logic                 set_rdy_q;

  modport master (
    output issue_valid, issue_rd, wb_valid, wb_tag, wb_val,
    input  issue_ready, issue_tag,
    input  set_reg, set_val, set_reg_q, set_val_q, set_rdy_q
  );

  modport slave (
    input  issue_valid, issue_rd, wb_valid, wb_tag, wb_val,
    output issue_ready, issue_tag,
    output set_reg, set_val, set_reg_q, set_val_q, set_rdy_q
  );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit unit driving register-file value and rename-tag writes
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  reorder_buffer_if.slave      bus,
  output logic [ROB_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH + 1)'(DEPTH);

  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 ent_valid_q [DEPTH];
  logic                 ent_done_q  [DEPTH];
  logic [4:0]           ent_rd_q    [DEPTH];
  logic [31:0]          ent_val_q   [DEPTH];

  logic                 latest_busy_q [32];
  logic [ROB_WIDTH-1:0] latest_tag_q  [32];

  logic [4:0]  out_reg_q, out_reg_d;
  logic [31:0] out_val_q, out_val_d;
  logic [4:0]  ren_reg_q, ren_reg_d;
  logic [31:0] ren_val_q, ren_val_d;
  logic        ren_rdy_q, ren_rdy_d;

  logic       commit_now;
  logic       need_q;
  logic       issue_fire;
  logic       wb_accept;
  logic [4:0] head_rd;

  assign head_rd    = ent_rd_q[head_q];
  assign commit_now = (count_q != '0) && ent_done_q[head_q];
  // A commit that retires the newest producer of rd must clear its rename entry,
  // so the shared tag-write port is reserved for it and issue is held off.
  assign need_q     = commit_now && (head_rd != 5'd0) && latest_busy_q[head_rd]
                      && (latest_tag_q[head_rd] == head_q);
  assign bus.issue_ready = (count_q != FULL_CNT) && !need_q;
  assign bus.issue_tag   = tail_q;
  assign issue_fire = bus.issue_valid && bus.issue_ready;
  assign wb_accept  = bus.wb_valid && ent_valid_q[bus.wb_tag] && !ent_done_q[bus.wb_tag];

  assign count         = count_q;
  assign bus.set_reg   = out_reg_q;
  assign bus.set_val   = out_val_q;
  assign bus.set_reg_q = ren_reg_q;
  assign bus.set_val_q = ren_val_q;
  assign bus.set_rdy_q = ren_rdy_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (ROB_WIDTH + 1)'(issue_fire) - (ROB_WIDTH + 1)'(commit_now);
    if (commit_now) head_d = head_q + ROB_WIDTH'(1);
    if (issue_fire) tail_d = tail_q + ROB_WIDTH'(1);
  end

  always_comb begin
    out_reg_d = 5'd0;
    out_val_d = 32'd0;
    ren_reg_d = 5'd0;
    ren_val_d = 32'd0;
    ren_rdy_d = 1'b0;
    if (commit_now) begin
      out_reg_d = head_rd;
      out_val_d = ent_val_q[head_q];
    end
    if (need_q) begin
      ren_reg_d = head_rd;
      ren_val_d = 32'(head_q);
      ren_rdy_d = 1'b1;
    end else if (issue_fire && (bus.issue_rd != 5'd0)) begin
      ren_reg_d = bus.issue_rd;
      ren_val_d = 32'(tail_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_reg_q <= 5'd0;
      out_val_q <= 32'd0;
      ren_reg_q <= 5'd0;
      ren_val_q <= 32'd0;
      ren_rdy_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid_q[i] <= 1'b0;
        ent_done_q[i]  <= 1'b0;
      end
      for (int r = 0; r < 32; r++) begin
        latest_busy_q[r] <= 1'b0;
      end
    end else if (rdy_in) begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_reg_q <= out_reg_d;
      out_val_q <= out_val_d;
      ren_reg_q <= ren_reg_d;
      ren_val_q <= ren_val_d;
      ren_rdy_q <= ren_rdy_d;
      if (wb_accept) begin
        ent_val_q[bus.wb_tag]  <= bus.wb_val;
        ent_done_q[bus.wb_tag] <= 1'b1;
      end
      if (commit_now) ent_valid_q[head_q] <= 1'b0;
      if (need_q) latest_busy_q[head_rd] <= 1'b0;
      // The tail slot is never valid when issue fires, so none of the writes above alias it.
      if (issue_fire) begin
        ent_valid_q[tail_q] <= 1'b1;
        ent_done_q[tail_q]  <= 1'b0;
        ent_rd_q[tail_q]    <= bus.issue_rd;
        if (bus.issue_rd != 5'd0) begin
          latest_busy_q[bus.issue_rd] <= 1'b1;
          latest_tag_q[bus.issue_rd]  <= tail_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic [4:0] count;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  reorder_buffer_if #(.ROB_WIDTH(4)) rob_if ();

  reorder_buffer #(.ROB_WIDTH(4)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bus      (rob_if),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rob_if.issue_valid = 1'b0;
    rob_if.wb_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    rob_if.issue_rd = 5'd0;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'd0;
    do_reset();
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (rob_if.issue_tag !== 4'd0) $display("FAIL reset_tag: got %0d exp 0", rob_if.issue_tag); else pass_cnt++;
    total_cnt++; if (rob_if.issue_ready !== 1'b1) $display("FAIL reset_ready: got %0b exp 1", rob_if.issue_ready); else pass_cnt++;
    total_cnt++; if ({rob_if.set_reg, rob_if.set_val, rob_if.set_reg_q, rob_if.set_val_q, rob_if.set_rdy_q} !== 75'd0)
      $display("FAIL reset_set_outputs: got %0h exp 0", {rob_if.set_reg, rob_if.set_val, rob_if.set_reg_q, rob_if.set_val_q, rob_if.set_rdy_q});
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd5;
    #1;
    total_cnt++; if (rob_if.issue_tag !== 4'd0) $display("FAIL single_tag: got %0d exp 0", rob_if.issue_tag); else pass_cnt++;
    step();
    rob_if.issue_valid = 1'b0;
    total_cnt++; if (rob_if.set_reg_q !== 5'd5 || rob_if.set_val_q !== 32'd0 || rob_if.set_rdy_q !== 1'b0)
      $display("FAIL single_rename: got %0d/%0d/%0b exp 5/0/0", rob_if.set_reg_q, rob_if.set_val_q, rob_if.set_rdy_q);
    else pass_cnt++;
    total_cnt++; if (count !== 5'd1) $display("FAIL single_count1: got %0d exp 1", count); else pass_cnt++;
    rob_if.wb_valid = 1'b1;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'hDEADBEEF;
    step();
    rob_if.wb_valid = 1'b0;
    total_cnt++; if (rob_if.set_reg_q !== 5'd0) $display("FAIL single_rename_idle: got %0d exp 0", rob_if.set_reg_q); else pass_cnt++;
    total_cnt++; if (rob_if.issue_ready !== 1'b0) $display("FAIL single_need_q_block: got %0b exp 0", rob_if.issue_ready); else pass_cnt++;
    step();
    total_cnt++; if (rob_if.set_reg !== 5'd5 || rob_if.set_val !== 32'hDEADBEEF)
      $display("FAIL single_commit: got %0d/%0h exp 5/deadbeef", rob_if.set_reg, rob_if.set_val);
    else pass_cnt++;
    total_cnt++; if (rob_if.set_reg_q !== 5'd5 || rob_if.set_val_q !== 32'd0 || rob_if.set_rdy_q !== 1'b1)
      $display("FAIL single_rename_clear: got %0d/%0d/%0b exp 5/0/1", rob_if.set_reg_q, rob_if.set_val_q, rob_if.set_rdy_q);
    else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL single_count0: got %0d exp 0", count); else pass_cnt++;
    step();
    total_cnt++; if (rob_if.set_reg !== 5'd0 || rob_if.set_val !== 32'd0 || rob_if.set_rdy_q !== 1'b0)
      $display("FAIL single_pulse: got %0d/%0h/%0b exp 0/0/0", rob_if.set_reg, rob_if.set_val, rob_if.set_rdy_q);
    else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    logic [3:0]  wb_tags [4];
    logic [31:0] wb_vals [4];
    wb_tags = '{4'd2, 4'd2, 4'd1, 4'd0};
    wb_vals = '{32'd30, 32'd99, 32'd20, 32'd10};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rob_if.issue_valid = 1'b1;
      rob_if.issue_rd = 5'(i + 1);
      step();
    end
    rob_if.issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rob_if.wb_valid = 1'b1;
      rob_if.wb_tag = wb_tags[i];
      rob_if.wb_val = wb_vals[i];
      step();
    end
    rob_if.wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (rob_if.set_reg !== 5'(i + 1) || rob_if.set_val !== 32'(10 * (i + 1)))
        $display("FAIL ooo_commit%0d: got %0d/%0d exp %0d/%0d", i, rob_if.set_reg, rob_if.set_val, i + 1, 10 * (i + 1));
      else pass_cnt++;
      total_cnt++; if (rob_if.set_reg_q !== 5'(i + 1) || rob_if.set_val_q !== 32'(i) || rob_if.set_rdy_q !== 1'b1)
        $display("FAIL ooo_rename%0d: got %0d/%0d/%0b exp %0d/%0d/1", i, rob_if.set_reg_q, rob_if.set_val_q, rob_if.set_rdy_q, i + 1, i);
      else pass_cnt++;
    end
    step();
    total_cnt++; if (rob_if.set_reg !== 5'd0 || count !== 5'd0)
      $display("FAIL ooo_drain: got reg %0d count %0d exp 0/0", rob_if.set_reg, count);
    else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rob_if.issue_valid = 1'b1;
      rob_if.issue_rd = 5'(i + 1);
      #1;
      total_cnt++; if (rob_if.issue_tag !== 4'(i)) $display("FAIL fill_tag%0d: got %0d exp %0d", i, rob_if.issue_tag, i); else pass_cnt++;
      step();
    end
    rob_if.issue_valid = 1'b0;
    total_cnt++; if (count !== 5'd16 || rob_if.issue_ready !== 1'b0)
      $display("FAIL full_state: got count %0d ready %0b exp 16/0", count, rob_if.issue_ready);
    else pass_cnt++;
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd20;
    step();
    rob_if.issue_valid = 1'b0;
    total_cnt++; if (count !== 5'd16 || rob_if.set_reg_q !== 5'd0)
      $display("FAIL full_reject: got count %0d rename %0d exp 16/0", count, rob_if.set_reg_q);
    else pass_cnt++;
    rob_if.wb_valid = 1'b1;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'h111;
    step();
    rob_if.wb_valid = 1'b0;
    step();
    total_cnt++; if (rob_if.set_reg !== 5'd1 || rob_if.set_val !== 32'h111 || count !== 5'd15)
      $display("FAIL full_commit: got %0d/%0h count %0d exp 1/111/15", rob_if.set_reg, rob_if.set_val, count);
    else pass_cnt++;
    total_cnt++; if (rob_if.issue_ready !== 1'b1 || rob_if.issue_tag !== 4'd0)
      $display("FAIL wrap_tag: got ready %0b tag %0d exp 1/0", rob_if.issue_ready, rob_if.issue_tag);
    else pass_cnt++;
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd9;
    step();
    rob_if.issue_valid = 1'b0;
    total_cnt++; if (rob_if.set_reg_q !== 5'd9 || rob_if.set_val_q !== 32'd0 || count !== 5'd16)
      $display("FAIL wrap_issue: got %0d/%0d count %0d exp 9/0/16", rob_if.set_reg_q, rob_if.set_val_q, count);
    else pass_cnt++;
  endtask

  task automatic test_superseded();
    do_reset();
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd7;
    step();
    step();
    rob_if.issue_valid = 1'b0;
    rob_if.wb_valid = 1'b1;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'h77;
    step();
    rob_if.wb_valid = 1'b0;
    total_cnt++; if (rob_if.issue_ready !== 1'b1) $display("FAIL super_ready: got %0b exp 1", rob_if.issue_ready); else pass_cnt++;
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd4;
    step();
    rob_if.issue_valid = 1'b0;
    total_cnt++; if (rob_if.set_reg !== 5'd7 || rob_if.set_val !== 32'h77)
      $display("FAIL super_commit: got %0d/%0h exp 7/77", rob_if.set_reg, rob_if.set_val);
    else pass_cnt++;
    total_cnt++; if (rob_if.set_reg_q !== 5'd4 || rob_if.set_val_q !== 32'd2 || rob_if.set_rdy_q !== 1'b0)
      $display("FAIL super_rename: got %0d/%0d/%0b exp 4/2/0", rob_if.set_reg_q, rob_if.set_val_q, rob_if.set_rdy_q);
    else pass_cnt++;
    total_cnt++; if (count !== 5'd2) $display("FAIL super_count: got %0d exp 2", count); else pass_cnt++;
  endtask

  task automatic test_rdy_hold();
    do_reset();
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd6;
    step();
    rob_if.issue_rd = 5'd0;
    step();
    total_cnt++; if (rob_if.set_reg_q !== 5'd0) $display("FAIL rd0_no_rename: got %0d exp 0", rob_if.set_reg_q); else pass_cnt++;
    rob_if.issue_valid = 1'b0;
    rob_if.wb_valid = 1'b1;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'h66;
    step();
    rob_if.wb_tag = 4'd1;
    rob_if.wb_val = 32'hA5A5;
    step();
    rob_if.wb_valid = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (rob_if.set_reg !== 5'd6 || rob_if.set_val !== 32'h66 || rob_if.set_rdy_q !== 1'b1 || count !== 5'd1)
        $display("FAIL rdy_hold%0d: got %0d/%0h/%0b count %0d exp 6/66/1/1", i, rob_if.set_reg, rob_if.set_val, rob_if.set_rdy_q, count);
      else pass_cnt++;
    end
    rdy = 1'b1;
    step();
    total_cnt++; if (rob_if.set_reg !== 5'd0 || rob_if.set_val !== 32'hA5A5 || rob_if.set_reg_q !== 5'd0 || count !== 5'd0)
      $display("FAIL rdy_resume: got %0d/%0h/%0d count %0d exp 0/a5a5/0/0", rob_if.set_reg, rob_if.set_val, rob_if.set_reg_q, count);
    else pass_cnt++;
    step();
    total_cnt++; if (rob_if.set_val !== 32'd0 || count !== 5'd0)
      $display("FAIL rdy_once: got val %0h count %0d exp 0/0", rob_if.set_val, count);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rob_if.issue_valid = 1'b1;
    rob_if.issue_rd = 5'd3;
    step();
    rob_if.issue_valid = 1'b0;
    rob_if.wb_valid = 1'b1;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'h33;
    step();
    rob_if.wb_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++; if (rob_if.set_reg !== 5'd0 || rob_if.set_val !== 32'd0 || rob_if.set_rdy_q !== 1'b0 || count !== 5'd0)
      $display("FAIL midreset_state: got %0d/%0h/%0b count %0d exp 0/0/0/0", rob_if.set_reg, rob_if.set_val, rob_if.set_rdy_q, count);
    else pass_cnt++;
    step();
    total_cnt++; if (rob_if.set_reg !== 5'd0 || rob_if.set_val !== 32'd0 || rob_if.issue_tag !== 4'd0)
      $display("FAIL midreset_no_commit: got %0d/%0h tag %0d exp 0/0/0", rob_if.set_reg, rob_if.set_val, rob_if.issue_tag);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1;
    rob_if.issue_valid = 1'b0;
    rob_if.issue_rd = 5'd0;
    rob_if.wb_valid = 1'b0;
    rob_if.wb_tag = 4'd0;
    rob_if.wb_val = 32'd0;
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_superseded();
    test_rdy_hold();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
